// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle of the receiver-FIFO read port, the register-bank write port and the
// frame status outputs of uart_rx_frame_ctrl.
// master: the frame controller. slave: the surrounding FIFO / register bank.
interface uart_rx_frame_ctrl_if;
  logic       rx_empty;
  logic [7:0] rx_dout;
  logic       rx_valid;
  logic       rx_rd_en;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    input  rx_empty, rx_dout, rx_valid, reg_wr_ready,
    output rx_rd_en, reg_wr_en, reg_wr_addr, reg_wr_data, frame_ok, frame_err, err_code, busy
  );

  modport slave (
    output rx_empty, rx_dout, rx_valid, reg_wr_ready,
    input  rx_rd_en, reg_wr_en, reg_wr_addr, reg_wr_data, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser between the UART receiver FIFO and the register bank.
// Frame: 0xA5, ADDR, LEN, LEN payload bytes, CHK (XOR of ADDR, LEN and payload).
// The payload is buffered and written out only once the checksum matches.
// Optional: define UART_FRAME_ERR_COUNT_EN to add the saturating err_count output.
module uart_rx_frame_ctrl #(
  parameter int unsigned CLK_IN        = 100000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_frame_ctrl_if.master bus
`ifdef UART_FRAME_ERR_COUNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  localparam logic [7:0]  SyncByte      = 8'hA5;
  localparam int unsigned TimeoutCycles = TIMEOUT_BYTES * 10 * (CLK_IN / BAUD);
  localparam int unsigned TmoW          = $clog2(TimeoutCycles) + 1;
  // idx has to reach len itself, so it needs one more code than the buffer address
  localparam int unsigned IdxW          = $clog2(MAX_LEN + 1);
  localparam int unsigned BufAw         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    StHunt,
    StAddr,
    StLen,
    StPayload,
    StCheck,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [7:0]        base_q, base_d;
  logic [IdxW-1:0]   len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        pay_q [MAX_LEN];

  logic              consume;
  logic              tmo_active;
  logic              expire;
  logic              pay_we;
  logic              rd_en;
  logic [IdxW-1:0]   idx_inc;

  // A byte only counts when it answers our own outstanding read.
  assign consume    = bus.rx_valid && pend_q;
  assign tmo_active = (state_q == StAddr) || (state_q == StLen) ||
                      (state_q == StPayload) || (state_q == StCheck);
  // An arriving byte beats a timeout expiring in the same cycle.
  assign expire     = tmo_active && !consume && (tmo_q == TmoW'(TimeoutCycles - 1));
  assign idx_inc    = idx_q + 1'b1;
  assign rd_en      = !bus.rx_empty && !pend_q && (state_q != StCommit);

  // Next-state, datapath updates and status pulses.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    pay_we      = 1'b0;
    pend_d      = rd_en ? 1'b1 : (bus.rx_valid ? 1'b0 : pend_q);
    tmo_d       = (tmo_active && !consume) ? tmo_q + 1'b1 : '0;

    unique case (state_q)
      StHunt: begin
        if (consume && bus.rx_dout == SyncByte) state_d = StAddr;
      end
      StAddr: begin
        if (consume) begin
          base_d  = bus.rx_dout;
          chk_d   = bus.rx_dout;
          state_d = StLen;
        end
      end
      StLen: begin
        if (consume) begin
          chk_d = chk_q ^ bus.rx_dout;
          if (bus.rx_dout == 8'd0 || 32'(bus.rx_dout) > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = StHunt;
          end else begin
            len_d   = bus.rx_dout[IdxW-1:0];
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (consume) begin
          pay_we = 1'b1;
          chk_d  = chk_q ^ bus.rx_dout;
          idx_d  = idx_inc;
          if (idx_inc == len_q) state_d = StCheck;
        end
      end
      StCheck: begin
        if (consume) begin
          if (bus.rx_dout == chk_q) begin
            idx_d   = '0;
            state_d = StCommit;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
            state_d     = StHunt;
          end
        end
      end
      StCommit: begin
        if (bus.reg_wr_ready) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            frame_ok_d = 1'b1;
            state_d    = StHunt;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (expire) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = StHunt;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      pend_q      <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Payload buffer; contents are only read in COMMIT, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pay_we) pay_q[idx_q[BufAw-1:0]] <= bus.rx_dout;
  end

  assign bus.rx_rd_en    = rd_en;
  assign bus.reg_wr_en   = (state_q == StCommit);
  assign bus.reg_wr_addr = (state_q == StCommit) ? base_q + 8'(idx_q) : 8'd0;
  assign bus.reg_wr_data = (state_q == StCommit) ? pay_q[idx_q[BufAw-1:0]] : 8'd0;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state_q != StHunt);

`ifdef UART_FRAME_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of dropped frames, aligned with the frame_err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (frame_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames plus randomized frame streams.
// Expected writes and events are derived from each frame's bytes as they are queued.
module tb_uart_rx_frame_ctrl;
  localparam int unsigned ClkIn   = 1000000;
  localparam int unsigned Baud    = 100000;
  localparam int unsigned MaxLen  = 16;
  localparam int unsigned TmoB    = 4;
  localparam int          TmoCyc  = TmoB * 10 * (ClkIn / Baud);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if bus ();
`ifdef UART_FRAME_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  uart_rx_frame_ctrl #(
    .CLK_IN        (ClkIn),
    .BAUD          (Baud),
    .MAX_LEN       (MaxLen),
    .TIMEOUT_BYTES (TmoB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef UART_FRAME_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          last_acc_cyc = -10;
  int          exp_err_total = 0;
  logic [7:0]  fifo_q [$];
  logic [15:0] exp_wr_q [$];
  int          exp_ev_q [$];
  bit          ready_force = 1'b1;
  bit          ready_val = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver FIFO model: data arrives the cycle after a read strobe.
  initial begin
    bit rd;
    bus.rx_empty     = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.rx_dout      = 8'h00;
    bus.reg_wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      rd = bus.rx_rd_en;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_dout  = fifo_q.pop_front();
      end else begin
        bus.rx_valid = 1'b0;
      end
      bus.rx_empty     = (fifo_q.size() == 0);
      bus.reg_wr_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Queue a frame and record what the controller must do with it.
  task automatic push_frame(input logic [7:0] addr, input logic [7:0] len,
                            input logic [7:0] data[$], input logic [7:0] chk);
    logic [7:0] ref_chk;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(addr);
    fifo_q.push_back(len);
    if (len == 8'd0 || len > MaxLen) begin
      exp_ev_q.push_back(2);
      return;
    end
    ref_chk = addr ^ len;
    for (int i = 0; i < int'(len); i++) begin
      fifo_q.push_back(data[i]);
      ref_chk ^= data[i];
    end
    fifo_q.push_back(chk);
    if (chk == ref_chk) begin
      for (int i = 0; i < int'(len); i++) exp_wr_q.push_back({8'(addr + i), data[i]});
      exp_ev_q.push_back(0);
    end else begin
      exp_ev_q.push_back(1);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !bus.busy && exp_wr_q.size() == 0 &&
          exp_ev_q.size() == 0 && !bus.rx_valid) break;
    end
    check_val("drain", fifo_q.size() + exp_wr_q.size() + exp_ev_q.size(), 0);
  endtask

  task automatic wait_wr_en(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.reg_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Output monitor: writes, hold-under-backpressure, frame events.
  initial begin
    bit          hold_prev;
    logic [15:0] hold_ad;
    int          code;
    hold_prev = 1'b0;
    hold_ad   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
        continue;
      end
      if (bus.frame_ok || bus.frame_err)
        check_val("ok_err_excl", {31'd0, bus.frame_ok & bus.frame_err}, 0);
      if (bus.reg_wr_en && hold_prev)
        check_val("wr_hold", {bus.reg_wr_addr, bus.reg_wr_data}, hold_ad);
      hold_prev = bus.reg_wr_en && !bus.reg_wr_ready;
      hold_ad   = {bus.reg_wr_addr, bus.reg_wr_data};
      if (bus.reg_wr_en && bus.reg_wr_ready) begin
        if (exp_wr_q.size() == 0) check_val("wr_expected", exp_wr_q.size(), 1);
        else check_val("wr", {bus.reg_wr_addr, bus.reg_wr_data}, exp_wr_q.pop_front());
        last_acc_cyc = cyc;
      end
      if (bus.frame_ok) begin
        check_val("ok_after_last_wr", cyc - last_acc_cyc, 1);
        check_val("ok_wr_en_low", bus.reg_wr_en, 0);
        if (exp_ev_q.size() == 0) check_val("ok_expected", exp_ev_q.size(), 1);
        else check_val("ev_ok", 0, exp_ev_q.pop_front());
      end
      if (bus.frame_err) begin
        if (exp_ev_q.size() == 0) begin
          check_val("err_expected", exp_ev_q.size(), 1);
        end else begin
          code = exp_ev_q.pop_front();
          check_val("ev_err_code", bus.err_code, code);
          if (code != 0) exp_err_total++;
        end
`ifdef UART_FRAME_ERR_COUNT_EN
        check_val("err_count", err_count, (exp_err_total > 255) ? 255 : exp_err_total);
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    int         t0, t1, kind, ng;
    logic [7:0] d [$];
    logic [7:0] addr, len, chk, b;

    repeat (3) @(negedge clk);
    check_val("reset_outs", {bus.rx_rd_en, bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data,
                             bus.frame_ok, bus.frame_err, bus.err_code, bus.busy}, 0);
    rst_n = 1'b1;

    // Plain valid frame.
    d = {8'h11, 8'h22};
    push_frame(8'h10, 8'h02, d, 8'h21);
    wait_idle(400);
    check_val("err_code_after_ok", bus.err_code, 0);

    // Address wrap with the first write held off for three cycles.
    ready_val = 1'b0;
    d = {8'hAA, 8'hBB};
    push_frame(8'hFF, 8'h02, d, 8'hEC);  // FF^02^AA^BB
    wait_wr_en(seen);
    check_val("bp_seen", seen, 1);
    check_val("bp_c0", {bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data}, 32'h1FFAA);
    repeat (2) begin
      @(negedge clk);
      check_val("bp_hold", {bus.reg_wr_en, bus.reg_wr_addr, bus.reg_wr_data}, 32'h1FFAA);
    end
    ready_val = 1'b1;
    @(negedge clk);
    check_val("bp_c3", {bus.reg_wr_en, bus.reg_wr_ready, bus.reg_wr_addr, bus.reg_wr_data},
              32'h3FFAA);
    wait_idle(400);

    // Bad checksum, then a good frame.
    d = {8'h11, 8'h22};
    push_frame(8'h10, 8'h02, d, 8'h20);
    push_frame(8'h10, 8'h02, d, 8'h21);
    wait_idle(400);
    check_val("err_code_chk_held", bus.err_code, 1);

    // Bad lengths, trailing garbage, then a good frame.
    push_frame(8'h10, 8'h00, d, 8'h00);
    push_frame(8'h10, 8'h11, d, 8'h00);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    push_frame(8'h40, 8'h02, d, 8'h40 ^ 8'h02 ^ 8'h11 ^ 8'h22);
    wait_idle(400);
    check_val("err_code_len_held", bus.err_code, 2);

    // Inter-byte timeout after the ADDR byte.
    exp_ev_q.push_back(3);
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h10);
    t0 = 0;
    t1 = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rx_valid && bus.rx_dout == 8'h10) begin
        t0 = cyc;
        seen = 1'b1;
        break;
      end
    end
    check_val("tmo_addr_seen", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < TmoCyc + 50; i++) begin
      @(negedge clk);
      if (bus.frame_err) begin
        t1 = cyc;
        seen = 1'b1;
        break;
      end
    end
    check_val("tmo_seen", seen, 1);
    // ADDR consumed on the edge after it is sampled; error rises TmoCyc edges later.
    check_val("tmo_latency", t1 - t0, TmoCyc + 1);
    check_val("tmo_busy", bus.busy, 0);
    check_val("tmo_code", bus.err_code, 3);
    wait_idle(50);

    // Garbage ahead of a valid frame.
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h3C);
    d = {8'h11, 8'h22};
    push_frame(8'h10, 8'h02, d, 8'h21);
    wait_idle(400);

    // Randomized frame stream with random backpressure.
    ready_force = 1'b0;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      addr = 8'($urandom);
      len  = 8'($urandom_range(1, MaxLen));
      d.delete();
      for (int i = 0; i < int'(len); i++) d.push_back(8'($urandom));
      chk = addr ^ len;
      foreach (d[i]) chk ^= d[i];
      if (kind == 6 || kind == 7) begin
        chk ^= 8'($urandom_range(1, 255));
        push_frame(addr, len, d, chk);
      end else if (kind == 8) begin
        len = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'($urandom_range(MaxLen + 1, 255));
        push_frame(addr, len, d, chk);
      end else if (kind == 9) begin
        ng = $urandom_range(1, 4);
        for (int i = 0; i < ng; i++) begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          fifo_q.push_back(b);
        end
      end else begin
        push_frame(addr, len, d, chk);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle(8000);

    // Reset while a commit is stalled.
    ready_force = 1'b1;
    ready_val = 1'b0;
    d = {8'h11, 8'h22};
    push_frame(8'h10, 8'h02, d, 8'h21);
    wait_wr_en(seen);
    check_val("rst_commit_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_commit_outs", {bus.reg_wr_en, bus.frame_ok, bus.frame_err, bus.busy,
                                  bus.rx_rd_en, bus.err_code}, 0);
`ifdef UART_FRAME_ERR_COUNT_EN
    check_val("rst_err_count", err_count, 0);
`endif
    exp_wr_q.delete();
    exp_ev_q.delete();
    exp_err_total = 0;
    repeat (2) @(negedge clk);
    check_val("rst_hold_idle", {bus.reg_wr_en, bus.frame_ok, bus.frame_err, bus.busy}, 0);
    rst_n = 1'b1;
    ready_val = 1'b1;
    push_frame(8'h80, 8'h02, d, 8'h80 ^ 8'h02 ^ 8'h11 ^ 8'h22);
    wait_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
